// File: rtl/divider_nr_param_pkg.sv
// ============================================================================
// Module : divider_pkg
// Shared state encoding and sizing helper for the non-restoring divider.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        CORR = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/divider_nr_param_if.sv
// ============================================================================
// Module : divider_nr_param_if
// Packed request/acknowledge bus between a divider client and the divider.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface divider_nr_param_if #(
    parameter int WIDTH = 8
) ();

    logic                 req;
    logic                 signed_mode;
    logic [2*WIDTH-1:0]   values;
    logic                 ack;
    logic                 busy;
    logic [2*WIDTH-1:0]   result;
    logic                 div_by_zero;
    logic                 overflow;

    modport master (
        output req, signed_mode, values,
        input  ack, busy, result, div_by_zero, overflow
    );

    modport slave (
        input  req, signed_mode, values,
        output ack, busy, result, div_by_zero, overflow
    );

endinterface

`default_nettype wire

// File: rtl/divider_nr_param_step.sv
// ============================================================================
// Module : nr_div_step
// One combinational non-restoring iteration on a WIDTH+1 bit partial remainder.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module nr_div_step #(
    parameter int WIDTH = 8
) (
    input  wire logic [WIDTH:0]   rem_in,
    input  wire logic             dividend_bit,
    input  wire logic [WIDTH-1:0] divisor,
    output logic      [WIDTH:0]   rem_out,
    output logic                  quot_bit
);

    logic [WIDTH:0] shifted;

    // Modular WIDTH+1 arithmetic is enough: the true result always fits in [-D, D).
    always_comb begin
        shifted = {rem_in[WIDTH-1:0], dividend_bit};
        if (rem_in[WIDTH] == 1'b0) begin
            rem_out = shifted - {1'b0, divisor};
        end else begin
            rem_out = shifted + {1'b0, divisor};
        end
        quot_bit = ~rem_out[WIDTH];
    end

endmodule

`default_nettype wire

// File: rtl/divider_nr_param.sv
// ============================================================================
// Module : divider_nr_param
// Iterative non-restoring divider, one quotient bit per clock, signed/unsigned.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module divider_nr_param
    import divider_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  wire logic          clk,
    input  wire logic          reset,
    divider_nr_param_if.slave  bus
);

    localparam int             CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    state_t             state, state_next;
    logic [WIDTH:0]     rem;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   dsr;
    logic [CW-1:0]      count;
    logic               smode, sign_q, sign_r, dz_pend, ov_pend;
    logic               ack_reg, busy_reg, dz_reg, ov_reg;
    logic [2*WIDTH-1:0] result_reg;

    logic [WIDTH-1:0]   dividend, divisor, mag_dividend, mag_divisor;
    logic [WIDTH:0]     step_rem, rem_fix, rem_fin;
    logic               step_bit;
    logic [WIDTH-1:0]   quo_fin;

    assign dividend     = bus.values[2*WIDTH-1:WIDTH];
    assign divisor      = bus.values[WIDTH-1:0];
    assign mag_dividend = (bus.signed_mode && dividend[WIDTH-1]) ? -dividend : dividend;
    assign mag_divisor  = (bus.signed_mode && divisor[WIDTH-1])  ? -divisor  : divisor;

    nr_div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in       (rem),
        .dividend_bit (quo[WIDTH-1]),
        .divisor      (dsr),
        .rem_out      (step_rem),
        .quot_bit     (step_bit)
    );

    assign rem_fix = rem[WIDTH] ? (rem + {1'b0, dsr}) : rem;
    assign quo_fin = (smode && sign_q) ? -quo : quo;
    assign rem_fin = (smode && sign_r && (rem_fix != '0)) ? -rem_fix : rem_fix;

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (bus.req) state_next = (divisor == '0) ? DONE : CALC;
            CALC: if (count == LAST) state_next = CORR;
            CORR: state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // quo doubles as the dividend shift register while quotient bits enter at the LSB.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rem        <= '0;
            quo        <= '0;
            dsr        <= '0;
            count      <= '0;
            smode      <= 1'b0;
            sign_q     <= 1'b0;
            sign_r     <= 1'b0;
            dz_pend    <= 1'b0;
            ov_pend    <= 1'b0;
            ack_reg    <= 1'b0;
            busy_reg   <= 1'b0;
            dz_reg     <= 1'b0;
            ov_reg     <= 1'b0;
            result_reg <= '0;
        end else begin
            ack_reg <= 1'b0;
            case (state)
                IDLE: begin
                    busy_reg <= bus.req;
                    if (bus.req) begin
                        smode   <= bus.signed_mode;
                        sign_q  <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        sign_r  <= dividend[WIDTH-1];
                        dsr     <= mag_divisor;
                        count   <= '0;
                        if (divisor == '0) begin
                            quo     <= '1;
                            rem     <= {1'b0, dividend};
                            dz_pend <= 1'b1;
                            ov_pend <= 1'b0;
                        end else begin
                            quo     <= mag_dividend;
                            rem     <= '0;
                            dz_pend <= 1'b0;
                            ov_pend <= bus.signed_mode && (dividend == MOST_NEG)
                                       && (divisor == '1);
                        end
                    end
                end
                CALC: begin
                    rem   <= step_rem;
                    quo   <= {quo[WIDTH-2:0], step_bit};
                    count <= count + 1'b1;
                end
                CORR: begin
                    rem <= rem_fin;
                    quo <= quo_fin;
                end
                DONE: begin
                    ack_reg    <= 1'b1;
                    result_reg <= {quo, rem[WIDTH-1:0]};
                    dz_reg     <= dz_pend;
                    ov_reg     <= ov_pend;
                end
                default: ;
            endcase
        end
    end

    assign bus.ack         = ack_reg;
    assign bus.busy        = busy_reg;
    assign bus.result      = result_reg;
    assign bus.div_by_zero = dz_reg;
    assign bus.overflow    = ov_reg;

endmodule

`default_nettype wire

// File: tb/tb_divider_nr_param.sv
// ============================================================================
// Module : tb_divider_nr_param
// Directed self-checking bench for divider_nr_param (WIDTH=8 and WIDTH=16).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_divider_nr_param;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    divider_nr_param_if #(.WIDTH(8))  bus8 ();
    divider_nr_param_if #(.WIDTH(16)) bus16 ();

    divider_nr_param #(.WIDTH(8))  dut8  (.clk(clk), .reset(reset), .bus(bus8));
    divider_nr_param #(.WIDTH(16)) dut16 (.clk(clk), .reset(reset), .bus(bus16));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one request, then stop at the negedge of the ack cycle (lat=-1 on timeout).
    task automatic run_op(input logic sm, input logic [15:0] v, output int lat, output int busy_cycles);
        @(negedge clk);
        bus8.req = 1'b1; bus8.signed_mode = sm; bus8.values = v;
        @(posedge clk);
        @(negedge clk);
        bus8.req = 1'b0;
        lat = -1; busy_cycles = 0;
        for (int k = 0; k < 40; k++) begin
            if (bus8.busy === 1'b1) busy_cycles++;
            if (bus8.ack === 1'b1) begin lat = k; break; end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        total++;
        if ({bus8.ack, bus8.busy, bus8.result, bus8.div_by_zero, bus8.overflow} !== 20'h0) begin
            bad++; $display("FAIL reset8: got %h want 0",
                {bus8.ack, bus8.busy, bus8.result, bus8.div_by_zero, bus8.overflow});
        end
        total++;
        if ({bus16.ack, bus16.busy, bus16.result} !== 34'h0) begin
            bad++; $display("FAIL reset16: got %h want 0", {bus16.ack, bus16.busy, bus16.result});
        end
    endtask

    task automatic test_unsigned();
        int lat, bc;
        run_op(1'b0, 16'hC807, lat, bc);
        total++; if (lat !== 10) begin bad++; $display("FAIL u_latency: got %0d want 10", lat); end
        total++; if (bus8.result !== 16'h1C04) begin bad++; $display("FAIL u_result: got %h want 1c04", bus8.result); end
        total++; if ({bus8.div_by_zero, bus8.overflow} !== 2'b00) begin
            bad++; $display("FAIL u_flags: got %b want 00", {bus8.div_by_zero, bus8.overflow}); end
        total++; if (bc !== 11) begin bad++; $display("FAIL u_busy_span: got %0d want 11", bc); end
        @(negedge clk);
        total++; if ({bus8.ack, bus8.busy} !== 2'b00) begin
            bad++; $display("FAIL u_after_ack: got %b want 00", {bus8.ack, bus8.busy}); end
        total++; if (bus8.result !== 16'h1C04) begin bad++; $display("FAIL u_hold: got %h want 1c04", bus8.result); end
    endtask

    task automatic test_signed();
        int lat, bc;
        run_op(1'b1, 16'h9C07, lat, bc);
        total++; if (bus8.result !== 16'hF2FE) begin bad++; $display("FAIL s_neg_dividend: got %h want f2fe", bus8.result); end
        total++; if (lat !== 10) begin bad++; $display("FAIL s_latency: got %0d want 10", lat); end
        run_op(1'b1, 16'h64F9, lat, bc);
        total++; if (bus8.result !== 16'hF202) begin bad++; $display("FAIL s_neg_divisor: got %h want f202", bus8.result); end
        run_op(1'b1, 16'hF9FE, lat, bc);  // -7 / -2 = 3 rem -1
        total++; if (bus8.result !== 16'h03FF) begin bad++; $display("FAIL s_both_neg: got %h want 03ff", bus8.result); end
    endtask

    task automatic test_div_zero();
        int lat, bc;
        for (int m = 0; m < 2; m++) begin
            run_op(m[0], 16'h3700, lat, bc);
            total++; if (lat !== 1) begin bad++; $display("FAIL dz_latency mode%0d: got %0d want 1", m, lat); end
            total++; if (bus8.result !== 16'hFF37) begin bad++; $display("FAIL dz_result mode%0d: got %h want ff37", m, bus8.result); end
            total++; if ({bus8.div_by_zero, bus8.overflow} !== 2'b10) begin
                bad++; $display("FAIL dz_flags mode%0d: got %b want 10", m, {bus8.div_by_zero, bus8.overflow}); end
        end
        run_op(1'b0, 16'h0905, lat, bc);  // 9/5 = 1 rem 4 clears the flag
        total++; if ({bus8.result, bus8.div_by_zero} !== {16'h0104, 1'b0}) begin
            bad++; $display("FAIL dz_clear: got %h/%b want 0104/0", bus8.result, bus8.div_by_zero); end
    endtask

    task automatic test_overflow();
        int lat, bc;
        run_op(1'b1, 16'h80FF, lat, bc);
        total++; if ({bus8.result, bus8.overflow, bus8.div_by_zero} !== {16'h8000, 2'b10}) begin
            bad++; $display("FAIL ov_signed: got %h/%b%b want 8000/10", bus8.result, bus8.overflow, bus8.div_by_zero); end
        run_op(1'b0, 16'h80FF, lat, bc);
        total++; if ({bus8.result, bus8.overflow} !== {16'h0080, 1'b0}) begin
            bad++; $display("FAIL ov_unsigned: got %h/%b want 0080/0", bus8.result, bus8.overflow); end
        run_op(1'b1, 16'h8001, lat, bc);  // -128 / 1 is not an overflow
        total++; if ({bus8.result, bus8.overflow} !== {16'h8000, 1'b0}) begin
            bad++; $display("FAIL ov_div_one: got %h/%b want 8000/0", bus8.result, bus8.overflow); end
    endtask

    task automatic test_req_ignored();
        int acks;
        int lat;
        @(negedge clk);
        bus8.req = 1'b1; bus8.signed_mode = 1'b0; bus8.values = 16'hC807;
        @(negedge clk);
        bus8.req = 1'b0;
        repeat (3) @(negedge clk);
        bus8.req = 1'b1; bus8.values = 16'h6405;
        @(negedge clk);
        bus8.req = 1'b0; bus8.values = 16'h0000;
        lat = -1;
        for (int k = 0; k < 30; k++) begin
            if (bus8.ack === 1'b1) begin lat = k; break; end
            @(negedge clk);
        end
        total++; if (lat < 0) begin bad++; $display("FAIL ign_timeout: got no ack want ack"); end
        total++; if (bus8.result !== 16'h1C04) begin bad++; $display("FAIL ign_result: got %h want 1c04", bus8.result); end
        acks = 0;
        repeat (15) begin @(negedge clk); if (bus8.ack === 1'b1) acks++; end
        total++; if (acks !== 0) begin bad++; $display("FAIL ign_extra_ack: got %0d want 0", acks); end
    endtask

    task automatic test_back_to_back();
        int times[3];
        int n;
        n = 0;
        @(negedge clk);
        bus8.req = 1'b1; bus8.signed_mode = 1'b1; bus8.values = 16'h9C07;
        for (int t = 0; t < 60; t++) begin
            @(negedge clk);
            if (bus8.ack === 1'b1) begin
                times[n] = t; n++;
                total++; if (bus8.result !== 16'hF2FE) begin bad++; $display("FAIL b2b_result%0d: got %h want f2fe", n, bus8.result); end
                if (n == 3) begin bus8.req = 1'b0; break; end
            end
        end
        total++; if (n !== 3) begin bad++; $display("FAIL b2b_count: got %0d want 3", n); end
        else begin
            total++; if (times[1] - times[0] !== 11) begin bad++; $display("FAIL b2b_period1: got %0d want 11", times[1] - times[0]); end
            total++; if (times[2] - times[1] !== 11) begin bad++; $display("FAIL b2b_period2: got %0d want 11", times[2] - times[1]); end
        end
        @(negedge clk);
        total++; if (bus8.busy !== 1'b0) begin bad++; $display("FAIL b2b_idle: got %b want 0", bus8.busy); end
    endtask

    task automatic test_reset_mid();
        int lat, bc, acks;
        acks = 0;
        @(negedge clk);
        bus8.req = 1'b1; bus8.signed_mode = 1'b0; bus8.values = 16'h6405;
        @(posedge clk);
        @(negedge clk);
        bus8.req = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (bus8.ack === 1'b1) acks++;
        end
        #1 reset = 1'b1;
        #1;
        total++; if ({bus8.ack, bus8.busy, bus8.result, bus8.div_by_zero, bus8.overflow} !== 20'h0) begin
            bad++; $display("FAIL rst_mid_outputs: got %h want 0",
                {bus8.ack, bus8.busy, bus8.result, bus8.div_by_zero, bus8.overflow}); end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (12) begin @(negedge clk); if (bus8.ack === 1'b1) acks++; end
        total++; if (acks !== 0) begin bad++; $display("FAIL rst_mid_no_ack: got %0d want 0", acks); end
        run_op(1'b1, 16'h9C07, lat, bc);
        total++; if ({bus8.result, lat} !== {16'hF2FE, 32'd10}) begin
            bad++; $display("FAIL rst_mid_recover: got %h lat %0d want f2fe lat 10", bus8.result, lat); end
    endtask

    task automatic test_width16();
        int lat;
        @(negedge clk);
        bus16.req = 1'b1; bus16.signed_mode = 1'b0; bus16.values = 32'hEA60_00FF;
        @(posedge clk);
        @(negedge clk);
        bus16.req = 1'b0;
        lat = -1;
        for (int k = 0; k < 40; k++) begin
            if (bus16.ack === 1'b1) begin lat = k; break; end
            @(negedge clk);
        end
        total++; if (lat !== 18) begin bad++; $display("FAIL w16_latency: got %0d want 18", lat); end
        total++; if (bus16.result !== 32'h00EB_004B) begin bad++; $display("FAIL w16_result: got %h want 00eb004b", bus16.result); end
    endtask

    initial begin
        total = 0; bad = 0;
        reset = 1'b1;
        bus8.req = 1'b0;  bus8.signed_mode = 1'b0;  bus8.values = '0;
        bus16.req = 1'b0; bus16.signed_mode = 1'b0; bus16.values = '0;
        repeat (2) @(negedge clk);
        test_reset();
        reset = 1'b0;
        test_unsigned();
        test_signed();
        test_div_zero();
        test_overflow();
        test_req_ignored();
        test_back_to_back();
        test_reset_mid();
        test_width16();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
